// File: rtl/clk_ratio_checker.sv
// clk_ratio_checker
//
// Observes a divided clock (sampled as data in the clk domain) and reports its
// period, its high time and whether it has settled on a stable period.
//
// Parameters:
//   CNT_W    width of the period/high-time counters (MAX = 2^CNT_W-1)
//   LOCK_CNT consecutive matching periods needed for lock (1..15)
//
// Ports:
//   clk         reference clock, all logic on its rising edge
//   rst         synchronous active-high reset
//   clk_in      divided clock under test, already synchronous to clk
//   ratio       last measured period in clk cycles
//   high_time   last measured high phase in clk cycles
//   ratio_valid ratio holds a complete measurement
//   locked      LOCK_CNT consecutive periods equalled ratio
//   mismatch    one-cycle pulse when a period differs from ratio
//   timeout     one-cycle pulse when no rising edge arrives within MAX cycles
module clk_ratio_checker #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  output logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] high_time,
  output logic             ratio_valid,
  output logic             locked,
  output logic             mismatch,
  output logic             timeout
);

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StTrack
  } state_e;

  localparam logic [CNT_W-1:0] CntMax  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [4:0]       LockCnt = 5'(LOCK_CNT);

  state_e           state_q;
  logic             in_q;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] hcnt_q;
  logic [3:0]       match_q;

  logic       rise;
  logic       fall;
  logic       pcnt_max;
  logic       tmo_hit;
  logic [4:0] match_inc;

  assign rise      = clk_in & ~in_q;
  assign fall      = ~clk_in & in_q;
  assign pcnt_max  = (pcnt_q == CntMax);
  // A rise in the same cycle wins, so a period of exactly MAX is still measured.
  assign tmo_hit   = (state_q != StIdle) && pcnt_max && !rise;
  assign match_inc = {1'b0, match_q} + 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      in_q        <= 1'b0;
      pcnt_q      <= '0;
      hcnt_q      <= '0;
      match_q     <= '0;
      ratio       <= '0;
      high_time   <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      in_q     <= clk_in;
      mismatch <= 1'b0;
      timeout  <= 1'b0;

      // On a rise cycle pcnt_q holds the length of the period that just ended.
      if (rise) begin
        pcnt_q <= CntOne;
      end else if (!pcnt_max) begin
        pcnt_q <= pcnt_q + CntOne;
      end

      if (rise) begin
        hcnt_q <= CntOne;
      end else if (clk_in && (hcnt_q != CntMax)) begin
        hcnt_q <= hcnt_q + CntOne;
      end

      if (fall && (state_q != StIdle)) begin
        high_time <= hcnt_q;
      end

      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (rise) begin
            ratio       <= pcnt_q;
            ratio_valid <= 1'b1;
            match_q     <= '0;
            state_q     <= StTrack;
          end
        end
        StTrack: begin
          if (rise) begin
            if (pcnt_q == ratio) begin
              match_q <= (match_inc >= LockCnt) ? LockCnt[3:0] : match_inc[3:0];
              if (match_inc == LockCnt) begin
                locked <= 1'b1;
              end
            end else begin
              mismatch <= 1'b1;
              ratio    <= pcnt_q;
              match_q  <= '0;
              locked   <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      // Loss of the input clock drops every result and rearms from IDLE.
      if (tmo_hit) begin
        timeout     <= 1'b1;
        state_q     <= StIdle;
        ratio       <= '0;
        high_time   <= '0;
        ratio_valid <= 1'b0;
        locked      <= 1'b0;
        match_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_clk_ratio_checker.sv
// Directed bench for clk_ratio_checker: a table of waveform bursts with the
// expected outputs after each burst, plus hand-written stuck-high and
// reset-while-locked sequences.
module tb_clk_ratio_checker;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned LOCK_CNT = 4;

  logic             clk;
  logic             rst;
  logic             clk_in;
  logic [CNT_W-1:0] ratio;
  logic [CNT_W-1:0] high_time;
  logic             ratio_valid;
  logic             locked;
  logic             mismatch;
  logic             timeout;

  clk_ratio_checker #(
    .CNT_W   (CNT_W),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_in     (clk_in),
    .ratio      (ratio),
    .high_time  (high_time),
    .ratio_valid(ratio_valid),
    .locked     (locked),
    .mismatch   (mismatch),
    .timeout    (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One burst: n periods of length per with hi high cycles, then expected state.
  typedef struct {
    int per;
    int hi;
    int n;
    int ratio;
    int high;
    int valid;
    int locked;
    int mism;
    int tmo;
  } vec_t;

  int   n_checks  = 0;
  int   n_fail    = 0;
  int   mism_cnt  = 0;
  int   tmo_cnt   = 0;
  int   both_cnt  = 0;
  int   long_cnt  = 0;
  logic prev_m    = 1'b0;
  logic prev_t    = 1'b0;

  vec_t vecs[18];

  function automatic vec_t mk(input int per, input int hi, input int n, input int r,
                              input int h, input int va, input int lk, input int m,
                              input int t);
    vec_t v;
    v.per = per; v.hi = hi; v.n = n; v.ratio = r; v.high = h;
    v.valid = va; v.locked = lk; v.mism = m; v.tmo = t;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive clk_in for one clk cycle and sample outputs just after the edge.
  task automatic step(input logic v);
    clk_in = v;
    @(posedge clk);
    #1;
    if (mismatch) mism_cnt++;
    if (timeout) tmo_cnt++;
    if (mismatch && timeout) both_cnt++;
    if ((mismatch && prev_m) || (timeout && prev_t)) long_cnt++;
    prev_m = mismatch;
    prev_t = timeout;
  endtask

  task automatic apply(input vec_t v, input string tag);
    mism_cnt = 0;
    tmo_cnt  = 0;
    for (int p = 0; p < v.n; p++) begin
      for (int i = 0; i < v.per; i++) begin
        step(i < v.hi);
      end
    end
    chk({tag, " ratio"}, int'(ratio), v.ratio);
    chk({tag, " high_time"}, int'(high_time), v.high);
    chk({tag, " ratio_valid"}, int'(ratio_valid), v.valid);
    chk({tag, " locked"}, int'(locked), v.locked);
    chk({tag, " mismatch pulses"}, mism_cnt, v.mism);
    chk({tag, " timeout pulses"}, tmo_cnt, v.tmo);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ratio"}, int'(ratio), 0);
    chk({tag, " high_time"}, int'(high_time), 0);
    chk({tag, " ratio_valid"}, int'(ratio_valid), 0);
    chk({tag, " locked"}, int'(locked), 0);
    chk({tag, " mismatch"}, int'(mismatch), 0);
    chk({tag, " timeout"}, int'(timeout), 0);
  endtask

  initial begin
    //                per  hi  n  ratio high v lk m t
    vecs[0]  = mk(2,   1,   1, 0,   1,   0, 0, 0, 0);  // rise 1: measuring
    vecs[1]  = mk(2,   1,   1, 2,   1,   1, 0, 0, 0);  // rise 2: ratio valid
    vecs[2]  = mk(2,   1,   3, 2,   1,   1, 0, 0, 0);  // rises 3..5
    vecs[3]  = mk(2,   1,   1, 2,   1,   1, 1, 0, 0);  // rise 6: locked
    vecs[4]  = mk(4,   2,   1, 2,   2,   1, 1, 0, 0);  // closes last /2 period
    vecs[5]  = mk(4,   2,   1, 4,   2,   1, 0, 1, 0);  // first /4 period
    vecs[6]  = mk(4,   2,   3, 4,   2,   1, 0, 0, 0);
    vecs[7]  = mk(4,   2,   1, 4,   2,   1, 1, 0, 0);
    vecs[8]  = mk(6,   3,   1, 4,   3,   1, 1, 0, 0);  // closes last /4 period
    vecs[9]  = mk(6,   3,   1, 6,   3,   1, 0, 1, 0);  // first 6-cycle period
    vecs[10] = mk(6,   3,   3, 6,   3,   1, 0, 0, 0);
    vecs[11] = mk(6,   3,   1, 6,   3,   1, 1, 0, 0);  // relock after 4 periods
    vecs[12] = mk(255, 100, 1, 6,   100, 1, 1, 0, 0);
    vecs[13] = mk(255, 100, 1, 255, 100, 1, 0, 1, 0);  // period of MAX measured
    vecs[14] = mk(256, 1,   1, 0,   0,   0, 0, 0, 1);  // low 255 cycles: timeout
    vecs[15] = mk(4,   2,   1, 0,   2,   0, 0, 0, 0);  // back in IDLE, rearm
    vecs[16] = mk(4,   2,   1, 4,   2,   1, 0, 0, 0);
    vecs[17] = mk(4,   2,   4, 4,   2,   1, 1, 0, 0);  // locked after 6 rises

    rst    = 1'b1;
    clk_in = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b0;
    chk_all_zero("reset");

    for (int k = 0; k < 18; k++) begin
      apply(vecs[k], $sformatf("row%0d", k));
    end

    // Stuck high from a locked divide-by-4.
    step(1'b1);
    tmo_cnt = 0;
    repeat (254) step(1'b1);
    chk("stuck early timeout", tmo_cnt, 0);
    chk("stuck high_time held", int'(high_time), 2);
    chk("stuck still locked", int'(locked), 1);
    step(1'b1);
    chk("stuck timeout pulse", int'(timeout), 1);
    chk("stuck ratio cleared", int'(ratio), 0);
    chk("stuck valid cleared", int'(ratio_valid), 0);
    chk("stuck locked cleared", int'(locked), 0);
    chk("stuck high_time cleared", int'(high_time), 0);
    step(1'b1);
    chk("stuck timeout one cycle", int'(timeout), 0);
    tmo_cnt = 0;
    repeat (300) step(1'b1);
    chk("idle stuck no timeout", tmo_cnt, 0);
    chk("idle stuck valid", int'(ratio_valid), 0);

    // Lock at /4, reset for one cycle with clk_in high, then relock.
    step(1'b0);
    apply(mk(4, 2, 6, 4, 2, 1, 1, 0, 0), "prelock");
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk_all_zero("midreset");
    apply(mk(4, 2, 5, 4, 2, 1, 0, 0, 0), "relock5");
    apply(mk(4, 2, 1, 4, 2, 1, 1, 0, 0), "relock6");

    chk("mismatch with timeout", both_cnt, 0);
    chk("pulse longer than one cycle", long_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
